// File: rtl/memory_map_if.sv
// CPU data-memory, keyboard and display-scanout signals of the memory map.
// The master modport drives requests and the slave modport answers them.
interface memory_map_if;
  logic        mem_load;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_busy;
  logic [15:0] kbd_code;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_data;

  modport master (
    output mem_load, mem_address, mem_wdata, kbd_code, vid_req, vid_addr,
    input  mem_rdata, mem_busy, vid_ack, vid_data
  );

  modport slave (
    input  mem_load, mem_address, mem_wdata, kbd_code, vid_req, vid_addr,
    output mem_rdata, mem_busy, vid_ack, vid_data
  );
endinterface

// File: rtl/memory_map.sv
// CPU data-memory responder: RAM, VRAM shared with display scanout, keyboard register.
// The single VRAM port is arbitrated by a small FSM; mem_busy flags display ownership.
module memory_map #(
  parameter int RAM_WORDS  = 16384,
  parameter int VRAM_WORDS = 8192,
  parameter int MIN_GAP    = 2
) (
  input logic         clk,
  input logic         reset,
  memory_map_if.slave bus
);
  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int VRAM_AW = $clog2(VRAM_WORDS);
  localparam int GAP_W   = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_V_ADDR, S_V_DATA} state_t;
  typedef enum logic [1:0] {RG_RAM, RG_VRAM, RG_KBD, RG_NONE} region_t;

  function automatic region_t decode(input logic [15:0] a);
    if (a[15:14] == 2'b00)       return RG_RAM;
    else if (a[15:13] == 3'b010) return RG_VRAM;
    else if (a == 16'h6000)      return RG_KBD;
    else                         return RG_NONE;
  endfunction

  logic [15:0]        r_ram [RAM_WORDS];
  logic [15:0]        r_vram [VRAM_WORDS];
  logic [15:0]        r_ram_q;
  logic [15:0]        r_vram_q;
  logic [15:0]        r_cpu_vram_q;
  logic [15:0]        r_kbd_q;
  logic [15:0]        r_vid_data;
  logic               r_vid_ack;
  logic               r_prev_idle;
  region_t            r_region;
  state_t             r_state;
  logic [GAP_W-1:0]   r_gap;

  region_t            w_region;
  logic               w_ram_we;
  logic               w_vram_we;
  logic [VRAM_AW-1:0] w_port_addr;
  logic [GAP_W-1:0]   w_gap_dec;
  logic [15:0]        w_rdata;

  assign w_region    = decode(bus.mem_address);
  assign w_ram_we    = bus.mem_load && (w_region == RG_RAM);
  assign w_vram_we   = bus.mem_load && (w_region == RG_VRAM) && (r_state == S_IDLE);
  assign w_port_addr = (r_state == S_V_ADDR) ? bus.vid_addr[VRAM_AW-1:0]
                                             : bus.mem_address[VRAM_AW-1:0];
  assign w_gap_dec   = (r_gap != '0) ? r_gap - GAP_W'(1) : '0;

  // Memory arrays and their read registers; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[bus.mem_address[RAM_AW-1:0]] <= bus.mem_wdata;
    r_ram_q <= r_ram[bus.mem_address[RAM_AW-1:0]];
    if (w_vram_we) r_vram[w_port_addr] <= bus.mem_wdata;
    r_vram_q <= r_vram[w_port_addr];
  end

  // Port-owner FSM. The display may take the port in the cycle the gap
  // counter reaches zero, giving exactly MIN_GAP busy-low cycles between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_vid_ack  <= 1'b0;
      r_vid_data <= '0;
    end else begin
      r_vid_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_gap <= w_gap_dec;
          if (bus.vid_req && (w_gap_dec == '0)) r_state <= S_V_ADDR;
        end
        S_V_ADDR: r_state <= S_V_DATA;
        S_V_DATA: begin
          r_vid_data <= r_vram_q;
          r_vid_ack  <= 1'b1;
          r_gap      <= GAP_W'(MIN_GAP);
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // CPU read path; the VRAM copy only accepts q produced from a CPU address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_idle  <= 1'b0;
      r_cpu_vram_q <= '0;
      r_region     <= RG_NONE;
      r_kbd_q      <= '0;
    end else begin
      r_prev_idle <= (r_state == S_IDLE);
      if (r_prev_idle) r_cpu_vram_q <= r_vram_q;
      r_region <= w_region;
      r_kbd_q  <= bus.kbd_code;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (r_region)
      RG_RAM:  w_rdata = r_ram_q;
      RG_VRAM: w_rdata = r_cpu_vram_q;
      RG_KBD:  w_rdata = r_kbd_q;
      default: w_rdata = '0;
    endcase
  end

  assign bus.mem_rdata = w_rdata;
  assign bus.mem_busy  = (r_state != S_IDLE);
  assign bus.vid_ack   = r_vid_ack;
  assign bus.vid_data  = r_vid_data;
endmodule

// File: tb/tb_memory_map.sv
// Directed bench for memory_map: RAM/VRAM/keyboard access and display arbitration.
module tb_memory_map;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  memory_map_if bus ();

  memory_map #(.RAM_WORDS(16384), .VRAM_WORDS(8192), .MIN_GAP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    bus.mem_load    = 1'b1;
    bus.mem_address = a;
    bus.mem_wdata   = d;
    tick();
    bus.mem_load = 1'b0;
  endtask

  // Sets the address and waits the region's read latency (RAM/kbd 1, VRAM 2).
  task automatic cpu_read(input logic [15:0] a, input int lat);
    bus.mem_load    = 1'b0;
    bus.mem_address = a;
    idle(lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    n_checks++;
    if (bus.mem_busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.mem_busy);
    end
    n_checks++;
    if (bus.vid_ack !== 1'b0) begin
      n_errors++; $display("FAIL reset_ack: got %b expected 0", bus.vid_ack);
    end
    n_checks++;
    if (bus.vid_data !== 16'h0000) begin
      n_errors++; $display("FAIL reset_vid_data: got %h expected 0000", bus.vid_data);
    end
    n_checks++;
    if (bus.mem_rdata !== 16'h0000) begin
      n_errors++; $display("FAIL reset_rdata: got %h expected 0000", bus.mem_rdata);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_ram_rw();
    cpu_write(16'h0010, 16'h1234);
    cpu_write(16'h0011, 16'h5678);
    cpu_read(16'h0010, 1);
    n_checks++;
    if (bus.mem_rdata !== 16'h1234) begin
      n_errors++; $display("FAIL ram_0010: got %h expected 1234", bus.mem_rdata);
    end
    cpu_read(16'h0011, 1);
    n_checks++;
    if (bus.mem_rdata !== 16'h5678) begin
      n_errors++; $display("FAIL ram_0011: got %h expected 5678", bus.mem_rdata);
    end
  endtask

  task automatic test_display_read();
    int busy_cnt;
    int ack_cnt;
    int ack_at;
    logic [15:0] data;
    busy_cnt = 0; ack_cnt = 0; ack_at = -1; data = '0;
    bus.vid_addr = 13'h0005;
    bus.vid_req  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.mem_busy) busy_cnt++;
      if (bus.vid_ack) begin
        ack_cnt++;
        data = bus.vid_data;
        if (ack_at < 0) ack_at = i;
        bus.vid_req = 1'b0;
      end
    end
    n_checks++;
    if (busy_cnt !== 2) begin
      n_errors++; $display("FAIL disp_busy_cycles: got %0d expected 2", busy_cnt);
    end
    n_checks++;
    if (ack_cnt !== 1) begin
      n_errors++; $display("FAIL disp_ack_count: got %0d expected 1", ack_cnt);
    end
    n_checks++;
    if (ack_at !== 2) begin
      n_errors++; $display("FAIL disp_ack_latency: got %0d expected 2", ack_at);
    end
    n_checks++;
    if (data !== 16'hBEEF) begin
      n_errors++; $display("FAIL disp_data: got %h expected beef", data);
    end
    bus.vid_req = 1'b0;
  endtask

  task automatic test_write_while_busy();
    logic [15:0] data;
    logic got_ack;
    data = '0; got_ack = 1'b0;
    bus.vid_addr = 13'h0006;
    bus.vid_req  = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_busy !== 1'b1) begin
      n_errors++; $display("FAIL wwb_busy: got %b expected 1", bus.mem_busy);
    end
    bus.mem_load    = 1'b1;
    bus.mem_address = 16'h4005;
    bus.mem_wdata   = 16'h1111;
    for (int i = 0; i < 6 && !got_ack; i++) begin
      tick();
      if (bus.vid_ack) begin
        got_ack = 1'b1;
        data = bus.vid_data;
        bus.vid_req = 1'b0;
      end
    end
    n_checks++;
    if (got_ack !== 1'b1 || data !== 16'hCAFE) begin
      n_errors++; $display("FAIL wwb_vid_data: got ack=%b %h expected ack=1 cafe", got_ack, data);
    end
    tick();
    bus.mem_load = 1'b0;
    cpu_read(16'h4005, 2);
    n_checks++;
    if (bus.mem_rdata !== 16'h1111) begin
      n_errors++; $display("FAIL wwb_landed: got %h expected 1111", bus.mem_rdata);
    end
    cpu_read(16'h4006, 2);
    n_checks++;
    if (bus.mem_rdata !== 16'hCAFE) begin
      n_errors++; $display("FAIL wwb_no_stray: got %h expected cafe", bus.mem_rdata);
    end
  endtask

  task automatic test_cpu_read_held();
    int bad;
    bad = 0;
    bus.vid_addr = 13'h0005;
    bus.vid_req  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 2) bus.mem_address = 16'h4100;
      if (i >= 4 && bus.mem_rdata !== 16'hA5A5) begin
        bad++;
        $display("FAIL held_rdata_%0d: got %h expected a5a5", i, bus.mem_rdata);
      end
    end
    bus.vid_req = 1'b0;
    n_checks++;
    if (bad != 0) n_errors++;
  endtask

  task automatic test_gap();
    logic exp_busy;
    logic exp_ack;
    bus.vid_addr = 13'h0006;
    bus.vid_req  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      exp_busy = ((i % 4) < 2);
      exp_ack  = ((i % 4) == 2);
      n_checks++;
      if (bus.mem_busy !== exp_busy) begin
        n_errors++; $display("FAIL gap_busy_%0d: got %b expected %b", i, bus.mem_busy, exp_busy);
      end
      n_checks++;
      if (bus.vid_ack !== exp_ack) begin
        n_errors++; $display("FAIL gap_ack_%0d: got %b expected %b", i, bus.vid_ack, exp_ack);
      end
    end
    bus.vid_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] data;
    logic got_ack;
    data = '0; got_ack = 1'b0;
    bus.vid_addr    = 13'h0009;
    bus.vid_req     = 1'b1;
    bus.mem_load    = 1'b1;
    bus.mem_address = 16'h4009;
    bus.mem_wdata   = 16'h9999;
    tick();
    bus.mem_load = 1'b0;
    for (int i = 0; i < 6 && !got_ack; i++) begin
      tick();
      if (bus.vid_ack) begin
        got_ack = 1'b1;
        data = bus.vid_data;
        bus.vid_req = 1'b0;
      end
    end
    bus.vid_req = 1'b0;
    n_checks++;
    if (got_ack !== 1'b1 || data !== 16'h9999) begin
      n_errors++; $display("FAIL b2b_vid_data: got ack=%b %h expected ack=1 9999", got_ack, data);
    end
  endtask

  task automatic test_kbd_unmapped();
    bus.kbd_code = 16'h0041;
    cpu_read(16'h6000, 1);
    n_checks++;
    if (bus.mem_rdata !== 16'h0041) begin
      n_errors++; $display("FAIL kbd_read: got %h expected 0041", bus.mem_rdata);
    end
    cpu_read(16'h7000, 1);
    n_checks++;
    if (bus.mem_rdata !== 16'h0000) begin
      n_errors++; $display("FAIL unmapped_read: got %h expected 0000", bus.mem_rdata);
    end
    cpu_write(16'h6000, 16'hFFFF);
    cpu_write(16'h7000, 16'hEEEE);
    cpu_read(16'h6000, 1);
    n_checks++;
    if (bus.mem_rdata !== 16'h0041) begin
      n_errors++; $display("FAIL kbd_write_ignored: got %h expected 0041", bus.mem_rdata);
    end
    cpu_read(16'h2000, 1);
    n_checks++;
    if (bus.mem_rdata !== 16'h0AAA) begin
      n_errors++; $display("FAIL ram_alias_2000: got %h expected 0aaa", bus.mem_rdata);
    end
    cpu_read(16'h3000, 1);
    n_checks++;
    if (bus.mem_rdata !== 16'h0CCC) begin
      n_errors++; $display("FAIL ram_alias_3000: got %h expected 0ccc", bus.mem_rdata);
    end
    cpu_read(16'h4000, 2);
    n_checks++;
    if (bus.mem_rdata !== 16'h0BBB) begin
      n_errors++; $display("FAIL vram_alias_0000: got %h expected 0bbb", bus.mem_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    bus.vid_addr = 13'h0005;
    bus.vid_req  = 1'b1;
    tick();
    n_checks++;
    if (bus.mem_busy !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", bus.mem_busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_busy !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.mem_busy);
    end
    n_checks++;
    if (bus.mem_rdata !== 16'h0000) begin
      n_errors++; $display("FAIL rst_mid_rdata: got %h expected 0000", bus.mem_rdata);
    end
    bus.vid_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.vid_ack) acks++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_errors++; $display("FAIL rst_mid_no_ack: got %0d acks expected 0", acks);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset           = 1'b1;
    bus.mem_load    = 1'b0;
    bus.mem_address = 16'h0000;
    bus.mem_wdata   = 16'h0000;
    bus.kbd_code    = 16'h0000;
    bus.vid_req     = 1'b0;
    bus.vid_addr    = 13'h0000;

    test_reset();
    cpu_write(16'h4005, 16'hBEEF);
    cpu_write(16'h4006, 16'hCAFE);
    cpu_write(16'h4000, 16'h0BBB);
    cpu_write(16'h4100, 16'hA5A5);
    cpu_write(16'h2000, 16'h0AAA);
    cpu_write(16'h3000, 16'h0CCC);
    test_ram_rw();
    test_display_read();
    idle(4);
    test_write_while_busy();
    idle(4);
    test_cpu_read_held();
    idle(4);
    test_gap();
    idle(4);
    test_back_to_back();
    idle(4);
    test_kbd_unmapped();
    idle(4);
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
